// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the multi-cycle control path: FSM states, opcodes,
// ALU operation codes and register write-back source selects.
package rv32i_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R_TYPE       = 7'b0110011;
  localparam logic [6:0] OP_S_TYPE       = 7'b0100011;
  localparam logic [6:0] OP_IL_TYPE      = 7'b0000011;
  localparam logic [6:0] OP_I_TYPE       = 7'b0010011;
  localparam logic [6:0] OP_B_TYPE       = 7'b1100011;
  localparam logic [6:0] OP_U_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_TYPE_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL_TYPE     = 7'b1101111;
  localparam logic [6:0] OP_JALR_TYPE    = 7'b1100111;

  localparam logic [3:0] ADD = 4'b0000;

  localparam logic [2:0] WB_SEL_ALU   = 3'b000;
  localparam logic [2:0] WB_SEL_DMEM  = 3'b001;
  localparam logic [2:0] WB_SEL_LUI   = 3'b010;
  localparam logic [2:0] WB_SEL_AUIPC = 3'b011;
  localparam logic [2:0] WB_SEL_PC4   = 3'b100;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath signal bundle. The master side is the controller;
// the slave side is the datapath that consumes the enables and selects.
interface multicycle_control_unit_if;
  logic [31:0] instr_code;
  logic        d_ready;
  logic        ir_en;
  logic        pc_en;
  logic [3:0]  alu_controls;
  logic        aluSrcMuxSel;
  logic        reg_wr_en;
  logic [2:0]  RegWdataSel;
  logic        d_wr_en;
  logic        d_rd_en;
  logic        branch;
  logic        JAL;
  logic        JAIR;
  logic        illegal_instr;
  logic        bus_err;
  logic [2:0]  state_o;

  modport master (
    input  instr_code, d_ready,
    output ir_en, pc_en, alu_controls, aluSrcMuxSel, reg_wr_en, RegWdataSel,
           d_wr_en, d_rd_en, branch, JAL, JAIR, illegal_instr, bus_err, state_o
  );

  modport slave (
    output instr_code, d_ready,
    input  ir_en, pc_en, alu_controls, aluSrcMuxSel, reg_wr_en, RegWdataSel,
           d_wr_en, d_rd_en, branch, JAL, JAIR, illegal_instr, bus_err, state_o
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct3/funct7[5] to ALU operation map; zero latency.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output logic [3:0] alu_controls_o
);

  always_comb begin
    alu_controls_o = ADD;
    case (opcode_i)
      OP_R_TYPE: alu_controls_o = {funct7_b5_i, funct3_i};
      // Only the shift-right immediate uses funct7[5]; other I-type bits there are immediate.
      OP_I_TYPE: alu_controls_o = {(funct3_i == 3'b101) && funct7_b5_i, funct3_i};
      OP_B_TYPE: alu_controls_o = {1'b0, funct3_i};
      default:   alu_controls_o = ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: one phase per cycle, Mealy outputs from state, opcode
// and d_ready; MEM stalls on d_ready and aborts with bus_err after MEM_TIMEOUT cycles.
module multicycle_control_unit
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [6:0]       opcode;
  logic [3:0]       alu_dec;
  logic             unused_instr_bits;

  assign opcode            = bus.instr_code[6:0];
  assign unused_instr_bits = ^{bus.instr_code[31], bus.instr_code[29:15], bus.instr_code[11:7]};
  assign bus.state_o       = state_q;

  alu_decoder u_alu_decoder (
    .opcode_i       (opcode),
    .funct3_i       (bus.instr_code[14:12]),
    .funct7_b5_i    (bus.instr_code[30]),
    .alu_controls_o (alu_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = '0;
    bus.ir_en         = 1'b0;
    bus.pc_en         = 1'b0;
    bus.alu_controls  = ADD;
    bus.aluSrcMuxSel  = 1'b0;
    bus.reg_wr_en     = 1'b0;
    bus.RegWdataSel   = WB_SEL_ALU;
    bus.d_wr_en       = 1'b0;
    bus.d_rd_en       = 1'b0;
    bus.branch        = 1'b0;
    bus.JAL           = 1'b0;
    bus.JAIR          = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.bus_err       = 1'b0;

    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        bus.ir_en = 1'b1;
        state_d   = DECODE;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        bus.alu_controls = alu_dec;
        bus.pc_en        = 1'b1;
        state_d          = FETCH;
        case (opcode)
          OP_R_TYPE: bus.reg_wr_en = 1'b1;
          OP_I_TYPE: begin
            bus.aluSrcMuxSel = 1'b1;
            bus.reg_wr_en    = 1'b1;
          end
          OP_U_TYPE_LUI: begin
            bus.reg_wr_en   = 1'b1;
            bus.RegWdataSel = WB_SEL_LUI;
          end
          OP_U_TYPE_AUIPC: begin
            bus.reg_wr_en   = 1'b1;
            bus.RegWdataSel = WB_SEL_AUIPC;
          end
          OP_JAL_TYPE: begin
            bus.reg_wr_en   = 1'b1;
            bus.RegWdataSel = WB_SEL_PC4;
            bus.JAL         = 1'b1;
          end
          OP_JALR_TYPE: begin
            bus.reg_wr_en   = 1'b1;
            bus.RegWdataSel = WB_SEL_PC4;
            bus.JAL         = 1'b1;
            bus.JAIR        = 1'b1;
          end
          OP_B_TYPE: bus.branch = 1'b1;
          OP_S_TYPE, OP_IL_TYPE: begin
            // PC must not advance until the memory access has completed.
            bus.aluSrcMuxSel = 1'b1;
            bus.pc_en        = 1'b0;
            state_d          = MEM;
          end
          default: bus.illegal_instr = 1'b1;
        endcase
      end
      MEM: begin
        bus.aluSrcMuxSel = 1'b1;
        bus.alu_controls = ADD;
        bus.d_wr_en      = (opcode == OP_S_TYPE);
        bus.d_rd_en      = (opcode != OP_S_TYPE);
        if (bus.d_ready) begin
          if (opcode == OP_S_TYPE) begin
            bus.pc_en = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end else if ((MEM_TIMEOUT > 0) && (wait_cnt_q == CNT_LAST)) begin
          bus.bus_err = 1'b1;
          bus.pc_en   = 1'b1;
          state_d     = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        bus.alu_controls = alu_dec;
        bus.reg_wr_en    = 1'b1;
        bus.RegWdataSel  = WB_SEL_DMEM;
        bus.pc_en        = 1'b1;
        state_d          = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each driven cycle queues its expected outputs; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       ir;
    logic       pc;
    logic [3:0] alu;
    logic       src;
    logic       rwe;
    logic [2:0] sel;
    logic       dwe;
    logic       dre;
    logic       br;
    logic       jal;
    logic       jair;
    logic       ill;
    logic       berr;
  } exp_t;

  localparam logic [31:0] I_ADD   = 32'h004182B3;
  localparam logic [31:0] I_SRAI  = 32'h4051D293;
  localparam logic [31:0] I_SUB   = 32'h40418233;
  localparam logic [31:0] I_LW    = 32'h0001A283;
  localparam logic [31:0] I_SW    = 32'h0041A423;
  localparam logic [31:0] I_BEQ   = 32'h00418463;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_AUIPC = 32'h00001297;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t  exp_q[$];
  string name_q[$];

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] alu, input logic src,
                              input logic pc, input logic rwe, input logic [2:0] sel,
                              input logic dwe, input logic dre, input logic br, input logic jal,
                              input logic jair, input logic ill, input logic berr);
    exp_t e;
    e      = '0;
    e.st   = st;   e.alu  = alu;  e.src = src; e.pc  = pc;  e.rwe = rwe; e.sel = sel;
    e.dwe  = dwe;  e.dre  = dre;  e.br  = br;  e.jal = jal; e.jair = jair;
    e.ill  = ill;  e.berr = berr;
    return e;
  endfunction

  function automatic exp_t fetch_e();
    exp_t e;
    e    = '0;
    e.st = 3'd1;
    e.ir = 1'b1;
    return e;
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [31:0] ins,
                     input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.instr_code = ins;
    bus.d_ready    = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fd(input string nm, input logic [31:0] ins, input logic rdy);
    cyc({nm, "_fetch"}, 1'b1, ins, rdy, fetch_e());
    cyc({nm, "_decode"}, 1'b1, ins, rdy, mk(3'd2, 4'h0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.state_o, bus.ir_en, bus.pc_en, bus.alu_controls, bus.aluSrcMuxSel,
             bus.reg_wr_en, bus.RegWdataSel, bus.d_wr_en, bus.d_rd_en, bus.branch,
             bus.JAL, bus.JAIR, bus.illegal_instr, bus.bus_err};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got st=%0d ir=%b pc=%b alu=%b src=%b rwe=%b sel=%b dwe=%b dre=%b br=%b jal=%b jair=%b ill=%b berr=%b, expected st=%0d ir=%b pc=%b alu=%b src=%b rwe=%b sel=%b dwe=%b dre=%b br=%b jal=%b jair=%b ill=%b berr=%b",
                 nm, got.st, got.ir, got.pc, got.alu, got.src, got.rwe, got.sel, got.dwe,
                 got.dre, got.br, got.jal, got.jair, got.ill, got.berr,
                 e.st, e.ir, e.pc, e.alu, e.src, e.rwe, e.sel, e.dwe, e.dre, e.br, e.jal,
                 e.jair, e.ill, e.berr);
      end
    end
  end

  initial begin
    exp_t z;
    exp_t sw_mem;
    exp_t lw_mem;
    z      = '0;
    sw_mem = mk(3'd4, 4'h0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    lw_mem = mk(3'd4, 4'h0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
    bus.instr_code = I_ADD;
    bus.d_ready    = 1'b0;

    cyc("reset_state", 1'b0, I_ADD, 1'b0, z);
    cyc("idle", 1'b1, I_ADD, 1'b0, z);

    // Single-cycle-style ops: FETCH, DECODE, EXECUTE, then FETCH again.
    fd("add", I_ADD, 1'b0);
    cyc("add_exec", 1'b1, I_ADD, 1'b0, mk(3'd3, 4'h0, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    fd("srai", I_SRAI, 1'b0);
    cyc("srai_exec", 1'b1, I_SRAI, 1'b0, mk(3'd3, 4'hD, 1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    fd("sub", I_SUB, 1'b0);
    cyc("sub_exec", 1'b1, I_SUB, 1'b0, mk(3'd3, 4'h8, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    // Load with two wait cycles, then a zero-wait load.
    fd("lw", I_LW, 1'b0);
    cyc("lw_exec", 1'b1, I_LW, 1'b0, mk(3'd3, 4'h0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_mem1", 1'b1, I_LW, 1'b0, lw_mem);
    cyc("lw_mem2", 1'b1, I_LW, 1'b0, lw_mem);
    cyc("lw_mem3", 1'b1, I_LW, 1'b1, lw_mem);
    cyc("lw_wb", 1'b1, I_LW, 1'b0, mk(3'd5, 4'h0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0));
    fd("lw0", I_LW, 1'b0);
    cyc("lw0_exec", 1'b1, I_LW, 1'b0, mk(3'd3, 4'h0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw0_mem", 1'b1, I_LW, 1'b1, lw_mem);
    cyc("lw0_wb", 1'b1, I_LW, 1'b0, mk(3'd5, 4'h0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0));

    // Store timeout after 4 MEM cycles, then a store whose ready lands on the last cycle.
    fd("sw_to", I_SW, 1'b0);
    cyc("sw_to_exec", 1'b1, I_SW, 1'b0, mk(3'd3, 4'h0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("sw_to_mem_wait", 1'b1, I_SW, 1'b0, sw_mem);
    cyc("sw_to_mem_buserr", 1'b1, I_SW, 1'b0, mk(3'd4, 4'h0, 1, 1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 1));
    fd("sw_rdy", I_SW, 1'b0);
    cyc("sw_rdy_exec", 1'b1, I_SW, 1'b0, mk(3'd3, 4'h0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("sw_rdy_mem_wait", 1'b1, I_SW, 1'b0, sw_mem);
    cyc("sw_rdy_mem_done", 1'b1, I_SW, 1'b1, mk(3'd4, 4'h0, 1, 1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0));

    fd("beq", I_BEQ, 1'b0);
    cyc("beq_exec", 1'b1, I_BEQ, 1'b0, mk(3'd3, 4'h0, 0, 1, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0));
    fd("illegal", I_ILL, 1'b0);
    cyc("illegal_exec", 1'b1, I_ILL, 1'b0, mk(3'd3, 4'h0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0));

    // d_ready held high outside MEM must have no effect.
    fd("lui", I_LUI, 1'b1);
    cyc("lui_exec", 1'b1, I_LUI, 1'b1, mk(3'd3, 4'h0, 0, 1, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0));
    fd("auipc", I_AUIPC, 1'b0);
    cyc("auipc_exec", 1'b1, I_AUIPC, 1'b0, mk(3'd3, 4'h0, 0, 1, 1, 3'b011, 0, 0, 0, 0, 0, 0, 0));
    fd("jal", I_JAL, 1'b0);
    cyc("jal_exec", 1'b1, I_JAL, 1'b0, mk(3'd3, 4'h0, 0, 1, 1, 3'b100, 0, 0, 0, 1, 0, 0, 0));
    fd("jalr", I_JALR, 1'b0);
    cyc("jalr_exec", 1'b1, I_JALR, 1'b0, mk(3'd3, 4'h0, 0, 1, 1, 3'b100, 0, 0, 0, 1, 1, 0, 0));

    // Reset asserted just after an edge while in MEM must clear outputs before the next edge.
    fd("swr", I_SW, 1'b0);
    cyc("swr_exec", 1'b1, I_SW, 1'b0, mk(3'd3, 4'h0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    cyc("swr_mem", 1'b1, I_SW, 1'b0, sw_mem);
    cyc("swr_reset_mid_mem", 1'b0, I_SW, 1'b0, z);
    cyc("swr_release_idle", 1'b1, I_SW, 1'b0, z);
    cyc("swr_after_fetch", 1'b1, I_ADD, 1'b0, fetch_e());

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
